cov_update_sequencer: RTL and testbench

- Owns the running covariance state for the 4-asset Q8.8 covariance datapath (update_cov) and sequences it, one price tick at a time.
- Holds the previous price, the moment matrix, the mean vector and the sample count T in registers.
- For each accepted tick it launches one update_cov operation, waits for completion, then commits or discards the result.
- Sits between the market-data tick decoder and the covariance datapath; downstream consumers read cov_out.

---
 rtl/hft_cov_pkg.sv | 24 ++
 rtl/cov_seq_timeout.sv | 36 +++
 rtl/cov_update_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_cov_update_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_cov_pkg.sv
// Shared Q8.8 types, constants and sequencer states for the 4-asset covariance datapath.
// Pure declarations: no latency, no flow control.
package hft_cov_pkg;

  localparam int          N_ASSETS = 4;
  localparam logic [15:0] T_SAT    = 16'h7FFF;

  typedef logic signed [15:0]                      q8_8_t;
  typedef q8_8_t [0:N_ASSETS-1]                    vec_t;
  typedef q8_8_t [0:N_ASSETS-1][0:N_ASSETS-1]      mat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_LAUNCH,
    ST_WAIT,
    ST_COMMIT
  } seq_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] cap);
    return (v >= cap) ? cap : v + 16'd1;
  endfunction

endpackage

// File: rtl/cov_seq_timeout.sv
// WAIT-phase cycle counter: zeroed by start, counts while run, expired on the last allowed cycle.
// Latency: expired is combinational from the count; no backpressure.
module cov_seq_timeout #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_100mhz,
  input  logic reset_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cov_update_sequencer.sv
// Owns covariance state and runs one update_cov launch/wait/commit per accepted tick; tick_ready only in IDLE.
// Latency: accept -> cov_valid = datapath latency + 3. COV_SEQ_WINDOW_CAP_EN caps T at WINDOW_T.
module cov_update_sequencer
  import hft_cov_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int WINDOW_T    = 256
) (
  input  logic        clk_100mhz,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        tick_valid,
  output logic        tick_ready,
  input  vec_t        tick_price,
  output logic        upd_reset,
  output logic        upd_valid,
  output vec_t        upd_old_p,
  output vec_t        upd_new_p,
  output vec_t        upd_old_mean,
  output mat_t        upd_old_moment,
  output logic [15:0] upd_T,
  input  logic        upd_ready,
  input  logic        upd_overflow,
  input  mat_t        upd_new_moment,
  input  mat_t        upd_new_cov,
  input  vec_t        upd_new_mean,
  output mat_t        cov_out,
  output logic        cov_valid,
  output logic [15:0] sample_count,
  output logic        err_overflow,
  output logic        err_timeout
);

`ifdef COV_SEQ_WINDOW_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif
  localparam logic [15:0] T_CAP = CAP_EN ? 16'(WINDOW_T) : T_SAT;

  seq_state_e  state_q, state_d;
  logic        primed_q, primed_d;
  vec_t        prev_p_q, prev_p_d;
  vec_t        cur_p_q, cur_p_d;
  mat_t        moment_q, moment_d;
  vec_t        mean_q, mean_d;
  logic [15:0] t_q, t_d;
  mat_t        cov_out_q, cov_out_d;
  logic        cov_valid_q, cov_valid_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_to_q, err_to_d;
  logic        upd_reset_q, upd_reset_d;
  mat_t        res_moment_q, res_moment_d;
  mat_t        res_cov_q, res_cov_d;
  vec_t        res_mean_q, res_mean_d;
  logic        res_ovf_q, res_ovf_d;

  logic        tmo_start, tmo_run, tmo_expired;
  logic        tick_acc;

  assign tmo_start = (state_q == ST_LAUNCH) || clear;
  assign tmo_run   = (state_q == ST_WAIT);

  cov_seq_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_100mhz (clk_100mhz),
    .reset_n    (reset_n),
    .start      (tmo_start),
    .run        (tmo_run),
    .expired    (tmo_expired)
  );

  // Hold off ticks while the datapath is being reset so no launch overlaps its reset.
  assign tick_ready = (state_q == ST_IDLE) && !upd_reset_q && !clear;
  assign tick_acc   = tick_valid && tick_ready;

  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    prev_p_d     = prev_p_q;
    cur_p_d      = cur_p_q;
    moment_d     = moment_q;
    mean_d       = mean_q;
    t_d          = t_q;
    cov_out_d    = cov_out_q;
    cov_valid_d  = 1'b0;
    err_ovf_d    = err_ovf_q;
    err_to_d     = err_to_q;
    upd_reset_d  = 1'b0;
    res_moment_d = res_moment_q;
    res_cov_d    = res_cov_q;
    res_mean_d   = res_mean_q;
    res_ovf_d    = res_ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        // The price is registered on accept in both paths; PRIME then copies it to prev_p.
        if (tick_acc) begin
          cur_p_d = tick_price;
          state_d = primed_q ? ST_LAUNCH : ST_PRIME;
        end
      end
      ST_PRIME: begin
        prev_p_d = cur_p_q;
        t_d      = 16'd1;
        primed_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (upd_ready) begin
          res_moment_d = upd_new_moment;
          res_cov_d    = upd_new_cov;
          res_mean_d   = upd_new_mean;
          res_ovf_d    = upd_overflow;
          state_d      = ST_COMMIT;
        end else if (tmo_expired) begin
          err_to_d    = 1'b1;
          upd_reset_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        prev_p_d = cur_p_q;
        if (res_ovf_q) begin
          err_ovf_d = 1'b1;
        end else begin
          moment_d    = res_moment_q;
          mean_d      = res_mean_q;
          cov_out_d   = res_cov_q;
          cov_valid_d = 1'b1;
          t_d         = sat_inc(t_q, T_CAP);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d      = ST_IDLE;
      primed_d     = 1'b0;
      prev_p_d     = '0;
      cur_p_d      = '0;
      moment_d     = '0;
      mean_d       = '0;
      t_d          = '0;
      cov_out_d    = '0;
      cov_valid_d  = 1'b0;
      err_ovf_d    = 1'b0;
      err_to_d     = 1'b0;
      upd_reset_d  = 1'b1;
      res_moment_d = '0;
      res_cov_d    = '0;
      res_mean_d   = '0;
      res_ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      primed_q     <= 1'b0;
      prev_p_q     <= '0;
      cur_p_q      <= '0;
      moment_q     <= '0;
      mean_q       <= '0;
      t_q          <= '0;
      cov_out_q    <= '0;
      cov_valid_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_to_q     <= 1'b0;
      upd_reset_q  <= 1'b1;
      res_moment_q <= '0;
      res_cov_q    <= '0;
      res_mean_q   <= '0;
      res_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      prev_p_q     <= prev_p_d;
      cur_p_q      <= cur_p_d;
      moment_q     <= moment_d;
      mean_q       <= mean_d;
      t_q          <= t_d;
      cov_out_q    <= cov_out_d;
      cov_valid_q  <= cov_valid_d;
      err_ovf_q    <= err_ovf_d;
      err_to_q     <= err_to_d;
      upd_reset_q  <= upd_reset_d;
      res_moment_q <= res_moment_d;
      res_cov_q    <= res_cov_d;
      res_mean_q   <= res_mean_d;
      res_ovf_q    <= res_ovf_d;
    end
  end

  assign upd_valid      = (state_q == ST_LAUNCH) && !clear;
  assign upd_reset      = upd_reset_q;
  assign upd_old_p      = prev_p_q;
  assign upd_new_p      = cur_p_q;
  assign upd_old_mean   = mean_q;
  assign upd_old_moment = moment_q;
  assign upd_T          = t_q;
  assign cov_out        = cov_out_q;
  assign cov_valid      = cov_valid_q;
  assign sample_count   = t_q;
  assign err_overflow   = err_ovf_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_cov_update_sequencer.sv
// Directed bench for cov_update_sequencer: table of tick transactions against a stub datapath,
// plus hand sequences for timeout, clear-in-flight and the T cap.
module tb_cov_update_sequencer;
  import hft_cov_pkg::*;

  logic        clk_100mhz = 1'b0;
  logic        reset_n;
  logic        clear = 1'b0;
  logic        tick_valid = 1'b0;
  logic        tick_ready;
  vec_t        tick_price = '0;
  logic        upd_reset, upd_valid;
  vec_t        upd_old_p, upd_new_p, upd_old_mean;
  mat_t        upd_old_moment;
  logic [15:0] upd_T;
  logic        upd_ready;
  logic        upd_overflow = 1'b0;
  mat_t        upd_new_moment = '0;
  mat_t        upd_new_cov = '0;
  vec_t        upd_new_mean = '0;
  mat_t        cov_out;
  logic        cov_valid;
  logic [15:0] sample_count;
  logic        err_overflow, err_timeout;

  always #5 clk_100mhz = ~clk_100mhz;

  cov_update_sequencer #(.TIMEOUT_CYC(64), .WINDOW_T(4)) dut (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .clear(clear),
    .tick_valid(tick_valid), .tick_ready(tick_ready), .tick_price(tick_price),
    .upd_reset(upd_reset), .upd_valid(upd_valid), .upd_old_p(upd_old_p),
    .upd_new_p(upd_new_p), .upd_old_mean(upd_old_mean), .upd_old_moment(upd_old_moment),
    .upd_T(upd_T), .upd_ready(upd_ready), .upd_overflow(upd_overflow),
    .upd_new_moment(upd_new_moment), .upd_new_cov(upd_new_cov), .upd_new_mean(upd_new_mean),
    .cov_out(cov_out), .cov_valid(cov_valid), .sample_count(sample_count),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  // Stub datapath and monitors
  int          stub_delay = 0;
  int          stub_cnt = 0;
  logic        stub_ovf = 1'b0;
  logic [15:0] stub_c00 = '0;
  vec_t        stub_newp = '0;
  logic        stub_rdy = 1'b0;
  logic        hand_rdy = 1'b0;
  int          launch_cnt = 0, cv_cnt = 0, urst_cnt = 0;
  vec_t        l_old_p = '0;
  logic [15:0] l_T = '0, l_mom00 = '0, l_mean0 = '0, max_T = '0;

  assign upd_ready = stub_rdy | hand_rdy;

  always @(negedge clk_100mhz) begin
    stub_rdy = 1'b0;
    if (upd_valid) begin
      launch_cnt++;
      l_old_p   = upd_old_p;
      l_T       = upd_T;
      l_mom00   = upd_old_moment[0][0];
      l_mean0   = upd_old_mean[0];
      stub_newp = upd_new_p;
      stub_cnt  = stub_delay;
      if (upd_T > max_T) max_T = upd_T;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) stub_rdy = 1'b1;
    end
    upd_new_cov          = '0;
    upd_new_cov[0][0]    = stub_c00;
    upd_new_moment       = '0;
    upd_new_moment[0][0] = 16'(stub_c00 + 16'd1);
    upd_new_mean         = stub_newp;
    upd_overflow         = stub_ovf;
    if (cov_valid) cv_cnt++;
    if (upd_reset) urst_cnt++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c); v[3] = 16'(d);
    return v;
  endfunction

  // Offers one tick; with wait_done, n = negedges from accept until tick_ready is back.
  task automatic run_tick(input vec_t p, input bit wait_done, output int n);
    int g;
    g = 0;
    while (!tick_ready && g < 300) begin @(negedge clk_100mhz); g++; end
    if (!tick_ready) chk("tick_ready_wait", {63'd0, tick_ready}, 64'd1);
    tick_valid = 1'b1;
    tick_price = p;
    @(negedge clk_100mhz);
    tick_valid = 1'b0;
    n = 1;
    if (wait_done) begin
      while (!tick_ready && n < 300) begin @(negedge clk_100mhz); n++; end
      #1;
    end
  endtask

  typedef struct {
    vec_t        p;
    int          delay;
    logic        ovf;
    logic [15:0] c00;
    int          exp_n;
    int          exp_launch;
    int          exp_cv;
    logic [15:0] exp_cov00;
    logic [15:0] exp_T;
    logic        exp_eovf;
    vec_t        exp_old_p;
    logic [15:0] exp_top;
    logic [15:0] exp_mom00;
    logic [15:0] exp_mean0;
  } vec_rec_t;

  vec_rec_t tbl [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, l0, c0, u0;
    logic [15:0] exp_sc, exp_max;

    tbl[0] = '{p:mkv(100,200,300,400), delay:5, ovf:1'b0, c00:16'h0000, exp_n:2, exp_launch:0,
               exp_cv:0, exp_cov00:16'h0000, exp_T:16'd1, exp_eovf:1'b0, exp_old_p:'0,
               exp_top:16'd0, exp_mom00:16'h0000, exp_mean0:16'd0};
    tbl[1] = '{p:mkv(110,210,310,410), delay:5, ovf:1'b0, c00:16'h0040, exp_n:8, exp_launch:1,
               exp_cv:1, exp_cov00:16'h0040, exp_T:16'd2, exp_eovf:1'b0, exp_old_p:mkv(100,200,300,400),
               exp_top:16'd1, exp_mom00:16'h0000, exp_mean0:16'd0};
    tbl[2] = '{p:mkv(120,220,320,420), delay:3, ovf:1'b1, c00:16'h0077, exp_n:6, exp_launch:1,
               exp_cv:0, exp_cov00:16'h0040, exp_T:16'd2, exp_eovf:1'b1, exp_old_p:mkv(110,210,310,410),
               exp_top:16'd2, exp_mom00:16'h0041, exp_mean0:16'd110};
    tbl[3] = '{p:mkv(130,230,330,430), delay:2, ovf:1'b0, c00:16'h0050, exp_n:5, exp_launch:1,
               exp_cv:1, exp_cov00:16'h0050, exp_T:16'd3, exp_eovf:1'b1, exp_old_p:mkv(120,220,320,420),
               exp_top:16'd2, exp_mom00:16'h0041, exp_mean0:16'd110};

    // Reset values
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_upd_reset", {63'd0, upd_reset}, 64'd1);
    chk("rst_tick_ready", {63'd0, tick_ready}, 64'd0);
    chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
    chk("rst_cov_valid", {63'd0, cov_valid}, 64'd0);
    chk("rst_sample_count", 64'(sample_count), 64'd0);
    chk("rst_errs", {62'd0, err_overflow, err_timeout}, 64'd0);
    chk("rst_cov_out00", 64'(cov_out[0][0]), 64'd0);
    repeat (3) @(negedge clk_100mhz);
    reset_n = 1'b1;
    @(negedge clk_100mhz);
    #1;
    chk("rel_upd_reset", {63'd0, upd_reset}, 64'd0);
    chk("rel_tick_ready", {63'd0, tick_ready}, 64'd1);

    for (int i = 0; i < 4; i++) begin
      stub_delay = tbl[i].delay;
      stub_ovf   = tbl[i].ovf;
      stub_c00   = tbl[i].c00;
      l0 = launch_cnt;
      c0 = cv_cnt;
      run_tick(tbl[i].p, 1'b1, n);
      chk($sformatf("v%0d_cycles", i), 64'(n), 64'(tbl[i].exp_n));
      chk($sformatf("v%0d_launches", i), 64'(launch_cnt - l0), 64'(tbl[i].exp_launch));
      chk($sformatf("v%0d_cov_valid", i), 64'(cv_cnt - c0), 64'(tbl[i].exp_cv));
      chk($sformatf("v%0d_cov00", i), 64'(cov_out[0][0]), 64'(tbl[i].exp_cov00));
      chk($sformatf("v%0d_T", i), 64'(sample_count), 64'(tbl[i].exp_T));
      chk($sformatf("v%0d_err_ovf", i), {63'd0, err_overflow}, {63'd0, tbl[i].exp_eovf});
      if (tbl[i].exp_launch != 0) begin
        chk($sformatf("v%0d_old_p", i), l_old_p, tbl[i].exp_old_p);
        chk($sformatf("v%0d_upd_T", i), 64'(l_T), 64'(tbl[i].exp_top));
        chk($sformatf("v%0d_old_mom00", i), 64'(l_mom00), 64'(tbl[i].exp_mom00));
        chk($sformatf("v%0d_old_mean0", i), 64'(l_mean0), 64'(tbl[i].exp_mean0));
      end
    end

    // Datapath never answers: timeout after 64 WAIT cycles, nothing committed
    stub_delay = 0;
    c0 = cv_cnt;
    u0 = urst_cnt;
    run_tick(mkv(140,240,340,440), 1'b1, n);
    chk("to_cycles", 64'(n), 64'd67);
    chk("to_err_timeout", {63'd0, err_timeout}, 64'd1);
    chk("to_upd_reset_pulses", 64'(urst_cnt - u0), 64'd1);
    chk("to_T", 64'(sample_count), 64'd3);
    chk("to_cov_valid", 64'(cv_cnt - c0), 64'd0);
    chk("to_err_ovf_sticky", {63'd0, err_overflow}, 64'd1);

    // First update after a timeout still uses the last committed prev_p
    stub_delay = 2;
    stub_c00   = 16'h0060;
    run_tick(mkv(150,250,350,450), 1'b1, n);
    chk("pt_cycles", 64'(n), 64'd5);
    chk("pt_old_p", l_old_p, mkv(130,230,330,430));
    chk("pt_upd_T", 64'(l_T), 64'd3);
    chk("pt_old_mom00", 64'(l_mom00), 64'h0051);
    chk("pt_old_mean0", 64'(l_mean0), 64'd130);
    chk("pt_T", 64'(sample_count), 64'd4);
    chk("pt_cov00", 64'(cov_out[0][0]), 64'h0060);

    // Clear while in WAIT, then a late upd_ready that must be ignored
    stub_delay = 0;
    stub_ovf   = 1'b0;
    stub_c00   = 16'h0099;
    c0 = cv_cnt;
    u0 = urst_cnt;
    run_tick(mkv(160,260,360,460), 1'b0, n);
    repeat (4) @(negedge clk_100mhz);
    clear = 1'b1;
    @(negedge clk_100mhz);
    clear = 1'b0;
    @(negedge clk_100mhz);
    hand_rdy = 1'b1;
    @(negedge clk_100mhz);
    hand_rdy = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    #1;
    chk("clr_cov_valid", 64'(cv_cnt - c0), 64'd0);
    chk("clr_T", 64'(sample_count), 64'd0);
    chk("clr_cov00", 64'(cov_out[0][0]), 64'd0);
    chk("clr_errs", {62'd0, err_overflow, err_timeout}, 64'd0);
    chk("clr_upd_reset_pulses", 64'(urst_cnt - u0), 64'd1);

    l0 = launch_cnt;
    run_tick(mkv(170,270,370,470), 1'b1, n);
    chk("clr_prime_cycles", 64'(n), 64'd2);
    chk("clr_prime_launches", 64'(launch_cnt - l0), 64'd0);
    chk("clr_prime_T", 64'(sample_count), 64'd1);

    // Ten successful updates: T either runs to 11 or holds at the window cap
    stub_delay = 1;
    max_T = '0;
    l0 = launch_cnt;
    c0 = cv_cnt;
    for (int k = 0; k < 10; k++) begin
      stub_c00 = 16'(k + 1);
      run_tick(mkv(200 + k, 300 + k, 400 + k, 500 + k), 1'b1, n);
      chk($sformatf("win%0d_cycles", k), 64'(n), 64'd4);
    end
`ifdef COV_SEQ_WINDOW_CAP_EN
    exp_sc  = 16'd4;
    exp_max = 16'd4;
`else
    exp_sc  = 16'd11;
    exp_max = 16'd10;
`endif
    chk("win_sample_count", 64'(sample_count), 64'(exp_sc));
    chk("win_max_upd_T", 64'(max_T), 64'(exp_max));
    chk("win_launches", 64'(launch_cnt - l0), 64'd10);
    chk("win_cov_valid", 64'(cv_cnt - c0), 64'd10);
    chk("win_cov00", 64'(cov_out[0][0]), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
